bit_scan_unit: RTL
==================

# bit_scan_unit

Parametrised, pipelined bit-scan unit for the ALU. Each operand is scanned in one of four modes: count leading zeros, trailing zeros, leading ones or trailing ones. Operands enter and results leave through valid/ready handshakes, and a tag travels with each operand. The unit sits beside the integer datapath and replaces the fixed 32-bit combinational zero counter with a registered, back-pressurable block of configurable width.

## Interface
Parameters:
- WIDTH, 32, operand width; power of two, 8..128.
- TAG_W, 4, width of the sideband tag carried with each operand; minimum 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand present.
- in_ready  out  1  unit accepts the operand this cycle.
- in_data  in  WIDTH  operand.
- in_op  in  2  mode: 00 CLZ, 01 CTZ, 10 CLO, 11 CTO.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CW  scan count, where CW = $clog2(WIDTH)+1.
- out_all  out  1  every bit equals the scanned value; out_count == WIDTH.
- out_tag  out  TAG_W  tag of this result.

## Operation
- A transfer occurs on a rising edge when valid && ready on that side.
- Normalisation reduces all four modes to CLZ:
  - Trailing modes (01, 11) bit-reverse the operand.
  - Ones modes (10, 11) invert the operand.
  - Both may apply together.
- Stage 1 (S1) registers the normalised word, the tag and s1_valid.
- Stage 2 (S2) runs a leading-zero tree on the S1 word.
  - It registers out_count, out_all, out_tag and out_valid.
- Count range is 0..WIDTH. out_all = (out_count == WIDTH).
- out_count is zero-extended to CW bits and never wraps.
- Define stall = out_valid && !out_ready.
  - While stall is high, neither stage loads.
  - While stall is low, both stages advance together. S1 loads the input transfer, or a bubble if in_valid is low. S2 loads S1.
- in_ready = !stall. It is combinational from out_valid and out_ready only, never from in_valid.
- Results leave in strict input order. Nothing is dropped or duplicated.
- Bubbles propagate; S2 loads s1_valid = 0 as out_valid = 0.
- Each transfer's in_op, in_data and in_tag are captured together at that transfer. The op is not looked up again later.

## Timing
- Latency: an operand accepted at edge N presents its result from edge N+2, provided no stall occurs in between.
- Throughput: one result per cycle while out_ready is held high.
- Reset, asynchronous, whenever rst_n is low:
  - s1_valid = 0, out_valid = 0.
  - out_count = 0, out_all = 0, out_tag = 0.
  - The S1 word is cleared.
  - in_ready = 1 immediately, because out_valid = 0.
- Reset asserted mid-operation discards all in-flight operands with no result emitted. The first accept after release behaves like an operand into an empty pipe.
- Under stall, out_count, out_all and out_tag hold stable until the cycle of the output transfer.
- When out_valid && out_ready and in_valid are all high in the same cycle, the output transfer and the input accept both occur; there is no bubble.
- The result becomes visible at S2 even with the pipe full and stalled input. The design needs no occupancy counter beyond s1_valid and out_valid.
- Critical path: the leading-zero tree sits between the S1 and S2 registers. Normalisation sits on the input side, before S1.

## Structure
- Package bit_scan_pkg holds:
  - the op encodings OP_CLZ, OP_CTZ, OP_CLO, OP_CTO as 2-bit localparams;
  - a function returning CW for a given WIDTH.
- One sub-module, lzc_tree, parametrised by WIDTH:
  - combinational, recursive halving;
  - each level returns a zero flag plus a partial count;
  - outputs count (CW bits) and all-zero.
  - The top level instantiates it once, between S1 and S2.
- The top level holds the normalisation logic, the two register stages and the handshake logic.

## Test plan
- WIDTH=32, out_ready=1:
  - CLZ 32'h0001_0000 -> count 15.
  - CTZ on the same operand -> count 16.
  - Both out_all=0, each 2 cycles after accept.
- Boundaries:
  - CLZ 32'h0 -> 32, out_all=1.
  - CLO 32'hFFFF_FFFF -> 32, out_all=1.
  - CLZ 32'h8000_0000 -> 0.
  - CTZ 32'h0000_0001 -> 0.
- Ones modes:
  - CTO 32'h0000_00FF -> 8.
  - CLO 32'hF000_0000 -> 4.
  - CTO 32'hFFFF_FFFE -> 0.
- Back-pressure:
  - Stimulus: stream tags 1..6 back-to-back, out_ready low for 3 cycles after the first result.
  - Response: in_ready low during the stall; outputs hold tag 1 stable; results then arrive in order, tags 1..6, with correct counts and no loss or duplication.
- Reset mid-operation:
  - Stimulus: assert rst_n low with both stages valid.
  - Response: outputs reset values immediately and in_ready=1. After release, the next operand CLZ 32'h0000_0100 -> 23 at latency 2, and no stale result appears.
- WIDTH=8, TAG_W=1 instance:
  - CLZ 8'h01 -> 7.
  - CTZ 8'h00 -> 8, out_all=1.
  - CW = 4 bits.

Source files
------------

// File: rtl/bit_scan_pkg.sv
// Shared definitions for the bit-scan unit: scan-mode encodings and count-width helper.
package bit_scan_pkg;

  localparam logic [1:0] OP_CLZ = 2'b00;
  localparam logic [1:0] OP_CTZ = 2'b01;
  localparam logic [1:0] OP_CLO = 2'b10;
  localparam logic [1:0] OP_CTO = 2'b11;

  // Count width able to hold 0..width inclusive.
  function automatic int unsigned cw_of(input int unsigned width);
    return 32'($clog2(width)) + 32'd1;
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built by recursive halving; each level yields
// an all-zero flag and a count in the range 0..WIDTH.
module lzc_tree
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW = cw_of(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count,
  output logic             all_zero
);

  if (WIDTH == 1) begin : g_leaf
    assign all_zero = ~data[0];
    assign count    = all_zero;
  end else begin : g_split
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned HCW  = cw_of(HALF);

    logic [HCW-1:0] hi_count;
    logic [HCW-1:0] lo_count;
    logic           hi_zero;
    logic           lo_zero;

    lzc_tree #(.WIDTH(HALF)) u_hi (
      .data     (data[WIDTH-1:HALF]),
      .count    (hi_count),
      .all_zero (hi_zero)
    );

    lzc_tree #(.WIDTH(HALF)) u_lo (
      .data     (data[HALF-1:0]),
      .count    (lo_count),
      .all_zero (lo_zero)
    );

    // An empty upper half contributes HALF zeros ahead of the lower half's count.
    assign all_zero = hi_zero & lo_zero;
    assign count    = hi_zero ? (CW'(HALF) + CW'(lo_count)) : CW'(hi_count);
  end

endmodule

// File: rtl/bit_scan_unit.sv
// Two-stage bit-scan unit: normalise CLZ/CTZ/CLO/CTO to CLZ before S1, run the
// leading-zero tree between S1 and S2, with valid/ready handshakes on both sides.
module bit_scan_unit
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned CW = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_all,
  output logic [TAG_W-1:0] out_tag
);

  logic             stall;
  logic             trailing;
  logic             ones;
  logic [WIDTH-1:0] reversed;
  logic [WIDTH-1:0] norm_word;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_word;
  logic [TAG_W-1:0] s1_tag;

  logic [CW-1:0]    lzc_count;
  logic             lzc_zero;

  // Both stages freeze together only when a presented result is not taken.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Trailing modes reverse, ones modes invert; afterwards every mode is a CLZ.
  always_comb begin
    trailing  = (in_op == OP_CTZ) || (in_op == OP_CTO);
    ones      = (in_op == OP_CLO) || (in_op == OP_CTO);
    reversed  = {<<{in_data}};
    norm_word = trailing ? reversed : in_data;
    if (ones) begin
      norm_word = ~norm_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_tag   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= norm_word;
        s1_tag  <= in_tag;
      end
    end
  end

  lzc_tree #(.WIDTH(WIDTH)) u_lzc (
    .data     (s1_word),
    .count    (lzc_count),
    .all_zero (lzc_zero)
  );

  // Payload only updates with a real operand so a bubble leaves the last result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_all   <= 1'b0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_count <= lzc_count;
        out_all   <= lzc_zero;
        out_tag   <= s1_tag;
      end
    end
  end

endmodule
